gcd_stein_unit: RTL and testbench
=================================

Name: gcd_stein_unit

Overview:
Parametrised successor to the single-channel subtractive GCD engine. Computes the GCD with the binary (Stein) algorithm over W-bit operands. Each request carries a tag that is returned with its result. A DEPTH-entry result FIFO decouples the engine from the consumer, so new operands are accepted while earlier results wait to drain. Sits behind the same val/rdy operand/result interfaces used by the existing GCD blocks and their testbench.

Parameters:
W, 16, operand/result width in bits (W >= 2)
TAG_W, 4, request tag width in bits (TAG_W >= 1)
DEPTH, 4, result FIFO entries (power of two, >= 2)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous reset, active-low
operands_bits_A  input  W  operand A
operands_bits_B  input  W  operand B
operands_tag  input  TAG_W  request tag
operands_val  input  1  operand valid
operands_rdy  output  1  operand ready
result_bits_data  output  W  GCD result (FIFO head)
result_tag  output  TAG_W  tag of the FIFO head
result_val  output  1  FIFO non-empty
result_rdy  input  1  consumer ready
busy  output  1  engine in CALC

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-low on `reset_n`.
- Reset (reset_n=0 at a clk edge): engine goes to IDLE; FIFO flushed (count=0, pointers=0); operands_rdy=0 during reset; result_val=0, busy=0, result_bits_data=0, result_tag=0. Reset mid-CALC aborts the operation and no result is produced.
- Engine FSM: IDLE -> CALC on accept; CALC -> IDLE in its termination cycle.
- operands_rdy = (state==IDLE) && (fifo_count < DEPTH) && reset_n. Accept = operands_val && operands_rdy at a clk edge. The accept latches A, B, and tag, and clears shift counter k (width clog2(W)+1).
- One operation in flight at a time. The accept rule guarantees a FIFO slot at push time.
- CALC step, one per cycle, first matching rule wins:
  1. A==0: push (B<<k, tag); go to IDLE.
  2. B==0: push (A<<k, tag); go to IDLE.
  3. A and B both even: A>>=1, B>>=1, k++.
  4. A even: A>>=1.
  5. B even: B>>=1.
  6. Both odd, A>=B: A=(A-B)>>1. Otherwise B=(B-A)>>1.
- Definitions and bounds:
  - gcd(0,0)=0; gcd(x,0)=gcd(0,x)=x.
  - All arithmetic is W-bit unsigned. The subtraction never underflows because of the compare.
  - CALC length N <= 2W+1 cycles.
- Latency: accept at edge E0; CALC cycles 1..N; push at the end of CALC cycle N; result_val=1 from the cycle after, i.e. N+1 cycles after E0. The next accept can occur at the edge ending CALC cycle N+1, i.e. IDLE holds for at least one cycle.
- FIFO:
  - Pop = result_val && result_rdy at a clk edge.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
  - Head data/tag are stable while result_val=1 and no pop occurs.
  - When empty, result_bits_data/result_tag hold their last value (don't-care).
- Full FIFO: operands_rdy=0 until a pop. The engine never stalls mid-CALC.
- busy = (state==CALC).

Optional Feature:
Macro GCD_CYCLE_COUNT_EN.
- When defined: adds output port result_cycles [15:0]. Each FIFO entry also stores the CALC cycle count N of its operation (saturating at 16'hFFFF), presented alongside the head entry.
- When undefined: the port, the counter, and the FIFO field are absent. All other behaviour is identical.

Test Plan:
- Reset, then (A=27, B=15, tag=3) with result_rdy=1 -> result_bits_data=3, result_tag=3; result_val rises 7 cycles after accept (N=6; count=6 with the macro).
- (40, 40, tag=1) -> result 40; exercises rule 3 three times, k=3; N=5.
- Edge cases: (0, 0) -> 0; (0, 250) -> 250; (250, 190) -> 10; (19, 27) -> 1, all in issue order with matching tags.
- result_rdy=0, issue DEPTH requests -> operands_rdy=0 after the DEPTH-th push; raise result_rdy for one cycle -> exactly one pop, operands_rdy reasserts, FIFO order preserved.
- Issue a new request while popping an older result in the same cycle as a push -> count unchanged, no loss or duplication.
- Deassert reset_n mid-CALC of (21, 49) -> result_val=0, FIFO empty, busy=0 next cycle; after release, (21, 49) -> result 7.

Source files
------------

// File: rtl/gcd_stein_unit.sv
// Binary (Stein) GCD engine with tagged requests and a DEPTH-entry result FIFO.
// Optional macro GCD_CYCLE_COUNT_EN adds a per-result CALC cycle count (result_cycles).
module gcd_stein_unit #(
  parameter int W     = 16,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [W-1:0]     operands_bits_A,
  input  logic [W-1:0]     operands_bits_B,
  input  logic [TAG_W-1:0] operands_tag,
  input  logic             operands_val,
  output logic             operands_rdy,
  output logic [W-1:0]     result_bits_data,
  output logic [TAG_W-1:0] result_tag,
  output logic             result_val,
  input  logic             result_rdy,
  output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [15:0]      result_cycles
`endif
);

  localparam int KW = $clog2(W) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     a_q, b_q, a_nxt, b_nxt;
  logic [KW-1:0]    k_q, k_nxt;
  logic [TAG_W-1:0] tag_q, tag_nxt;
  logic             accept, push, pop;
  logic [W-1:0]     push_data;

  logic [W-1:0]     data_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

`ifdef GCD_CYCLE_COUNT_EN
  logic [15:0]      cyc_q, cyc_nxt;
  logic [15:0]      cyc_mem [DEPTH];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign operands_rdy = (state == IDLE) && (count < CW'(DEPTH)) && reset_n;
  assign accept       = operands_val && operands_rdy;
  assign result_val   = (count != '0);
  assign pop          = result_val && result_rdy;
  assign busy         = (state == CALC);

  assign result_bits_data = data_mem[rd_ptr];
  assign result_tag       = tag_mem[rd_ptr];
`ifdef GCD_CYCLE_COUNT_EN
  assign result_cycles    = cyc_mem[rd_ptr];
`endif

  // Engine: one Stein reduction step per CALC cycle; the zero-operand cycle pushes.
  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    k_nxt     = k_q;
    tag_nxt   = tag_q;
    push      = 1'b0;
    push_data = '0;
`ifdef GCD_CYCLE_COUNT_EN
    cyc_nxt   = cyc_q;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = CALC;
          a_nxt     = operands_bits_A;
          b_nxt     = operands_bits_B;
          k_nxt     = '0;
          tag_nxt   = operands_tag;
`ifdef GCD_CYCLE_COUNT_EN
          cyc_nxt   = 16'd1;
`endif
        end
      end
      CALC: begin
        if (a_q == '0) begin
          push      = 1'b1;
          push_data = b_q << k_q;
          state_nxt = IDLE;
        end else if (b_q == '0) begin
          push      = 1'b1;
          push_data = a_q << k_q;
          state_nxt = IDLE;
        end else if (!a_q[0] && !b_q[0]) begin
          a_nxt = a_q >> 1;
          b_nxt = b_q >> 1;
          k_nxt = k_q + 1'b1;
        end else if (!a_q[0]) begin
          a_nxt = a_q >> 1;
        end else if (!b_q[0]) begin
          b_nxt = b_q >> 1;
        end else if (a_q >= b_q) begin
          a_nxt = (a_q - b_q) >> 1;
        end else begin
          b_nxt = (b_q - a_q) >> 1;
        end
`ifdef GCD_CYCLE_COUNT_EN
        if (!push) cyc_nxt = sat_inc(cyc_q);
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Operand datapath carries no reset; it is reloaded on every accept.
  always_ff @(posedge clk) begin
    a_q   <= a_nxt;
    b_q   <= b_nxt;
    k_q   <= k_nxt;
    tag_q <= tag_nxt;
`ifdef GCD_CYCLE_COUNT_EN
    cyc_q <= cyc_nxt;
`endif
  end

  // Result FIFO: the accept rule guarantees a free slot whenever push fires.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
`ifdef GCD_CYCLE_COUNT_EN
        cyc_mem[i]  <= '0;
`endif
      end
    end else if (push) begin
      data_mem[wr_ptr] <= push_data;
      tag_mem[wr_ptr]  <= tag_q;
`ifdef GCD_CYCLE_COUNT_EN
      cyc_mem[wr_ptr]  <= cyc_q;
`endif
    end
  end

endmodule

// File: tb/tb_gcd_stein_unit.sv
// Randomized self-checking bench for gcd_stein_unit against a Euclid reference model.
module tb_gcd_stein_unit;

  localparam int W     = 16;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [W-1:0]     operands_bits_A, operands_bits_B;
  logic [TAG_W-1:0] operands_tag;
  logic             operands_val, operands_rdy;
  logic [W-1:0]     result_bits_data;
  logic [TAG_W-1:0] result_tag;
  logic             result_val, result_rdy, busy;
`ifdef GCD_CYCLE_COUNT_EN
  logic [15:0]      result_cycles;
`endif

  gcd_stein_unit #(.W(W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .operands_bits_A  (operands_bits_A),
    .operands_bits_B  (operands_bits_B),
    .operands_tag     (operands_tag),
    .operands_val     (operands_val),
    .operands_rdy     (operands_rdy),
    .result_bits_data (result_bits_data),
    .result_tag       (result_tag),
    .result_val       (result_val),
    .result_rdy       (result_rdy),
    .busy             (busy)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .result_cycles    (result_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     d;
    logic [TAG_W-1:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pops     = 0;
  bit   rand_mode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Euclid by remainder: independent of the shift/subtract formulation.
  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int x = a;
    int y = b;
    while (y != 0) begin
      int r = x % y;
      x = y;
      y = r;
    end
    return W'(x);
  endfunction

  // A pop takes effect at the next rising edge; inputs only change #1 after edges.
  always @(negedge clk) begin
    if (reset_n && result_val && result_rdy) begin
      if (exp_q.size() == 0) begin
        check("spurious_pop", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_data", result_bits_data, e.d);
        check("res_tag", result_tag, e.t);
      end
      pops++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) result_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TAG_W-1:0] t);
    int n = 0;
    operands_bits_A = a;
    operands_bits_B = b;
    operands_tag    = t;
    operands_val    = 1'b1;
    while (!operands_rdy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!operands_rdy) begin
      check("accept_timeout", 0, 1);
      operands_val = 1'b0;
      return;
    end
    exp_q.push_back('{gcd_ref(a, b), t});
    @(posedge clk);
    #1;
    operands_val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    result_rdy = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_empty", result_val, 0);
  endtask

  task automatic lat_test(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [TAG_W-1:0] t, input int n_exp);
    int n = 0;
    result_rdy = 1'b1;
    send(a, b, t);
    check("busy_after_accept", busy, 1);
    while (!result_val && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, n_exp);
    check("idle_after_push", busy, 0);
    check("rdy_after_push", operands_rdy, 1);
`ifdef GCD_CYCLE_COUNT_EN
    check("cycles", result_cycles, n_exp);
`endif
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    reset_n = 1'b0;
    operands_bits_A = '0;
    operands_bits_B = '0;
    operands_tag = '0;
    operands_val = 1'b1;
    result_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", operands_rdy, 0);
    check("rst_val", result_val, 0);
    check("rst_busy", busy, 0);
    check("rst_data", result_bits_data, 0);
    check("rst_tag", result_tag, 0);
    operands_val = 1'b0;
    reset_n = 1'b1;
    #1;
    check("post_rst_rdy", operands_rdy, 1);
    @(posedge clk);
    #1;

    lat_test(16'd27, 16'd15, 4'd3, 6);
    lat_test(16'd40, 16'd40, 4'd1, 5);

    send(16'd0, 16'd0, 4'd4);
    send(16'd0, 16'd250, 4'd5);
    send(16'd250, 16'd190, 4'd6);
    send(16'd19, 16'd27, 4'd7);
    drain();

    // Fill the FIFO with the consumer stalled.
    result_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(W'(30 + 6 * i), W'(18 + 4 * i), TAG_W'(i + 8));
    for (int n = 0; busy && n < 100; n++) begin
      @(posedge clk);
      #1;
    end
    check("full_rdy", operands_rdy, 0);
    check("full_val", result_val, 1);
    repeat (3) @(posedge clk);
    #1;
    check("full_rdy_hold", operands_rdy, 0);
    p0 = pops;
    result_rdy = 1'b1;
    @(posedge clk);
    #1;
    result_rdy = 1'b0;
    check("one_pop", pops - p0, 1);
    check("rdy_reassert", operands_rdy, 1);
    check("queue_left", exp_q.size(), DEPTH - 1);
    drain();

    // Pop coinciding with the push of (27,15), whose CALC length is 6.
    result_rdy = 1'b0;
    send(16'd8, 16'd12, 4'd2);
    send(16'd9, 16'd6, 4'd12);
    p0 = pops;
    send(16'd27, 16'd15, 4'd13);
    repeat (5) @(posedge clk);
    #1;
    check("pre_push_busy", busy, 1);
    result_rdy = 1'b1;
    @(posedge clk);
    #1;
    result_rdy = 1'b0;
    check("push_pop_idle", busy, 0);
    check("push_pop_count", pops - p0, 1);
    check("push_pop_val", result_val, 1);
    drain();
    check("push_pop_total", pops - p0, 3);

    // Reset in the middle of CALC discards the operation.
    result_rdy = 1'b1;
    send(16'd21, 16'd49, 4'd2);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_val", result_val, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rdy", operands_rdy, 0);
    exp_q.delete();
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_result", result_val, 0);
    send(16'd21, 16'd49, 4'd9);
    drain();

    rand_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = '0;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 3) == 0) begin
        a = W'($urandom_range(1, 255)) << $urandom_range(0, 6);
        b = W'($urandom_range(1, 255)) << $urandom_range(0, 6);
      end
      send(a, b, TAG_W'($urandom));
    end
    rand_mode = 0;
    @(posedge clk);
    #2;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
